// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: receive-frame states, err_code values and default sync byte
package uart_frame_pkg;
   typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CSUM, HOLD} state_e;
   localparam logic [1:0] ERR_LINE     = 2'd0;
   localparam logic [1:0] ERR_CSUM     = 2'd1;
   localparam logic [1:0] ERR_LEN      = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;
   localparam logic [7:0] SYNC_DEFAULT = 8'hAA;
endpackage

// File: rtl/uart_frame_timeout.sv
// uart_frame_timeout: idle cycle counter, cleared on demand, pulses expire_o on the TIMEOUT-th idle cycle
module uart_frame_timeout #(
   parameter int TIMEOUT = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic run_i,
   input  logic clr_i,
   output logic expire_o
);
   localparam int W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
   logic [W-1:0] cnt_q;
   // count idle cycles while running; an accepted byte or leaving the frame states restarts from zero
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else cnt_q <= (run_i && !clr_i) ? cnt_q + W'(1) : '0;
   assign expire_o = run_i && !clr_i && cnt_q == LAST;
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: hunts for SYNC, assembles cmd/len/payload frames and holds them for downstream; define UART_FRAME_CSUM_EN to require a trailing XOR checksum byte
module uart_rx_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter logic [7:0] SYNC    = SYNC_DEFAULT,
   parameter int         MAX_LEN = 8,
   parameter int         TIMEOUT = 100000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           rx_data,
   input  logic                 rx_sent,
   input  logic [3:0]           rx_error,
   output logic                 rx_ack,
   output logic                 frame_valid,
   input  logic                 frame_ready,
   output logic [7:0]           frame_cmd,
   output logic [3:0]           frame_len,
   output logic [8*MAX_LEN-1:0] frame_payload,
   output logic                 frame_err,
   output logic [1:0]           err_code
);
`ifdef UART_FRAME_CSUM_EN
   localparam state_e DATA_DONE = CSUM;
`else
   localparam state_e DATA_DONE = HOLD;
`endif
   localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);
   state_e     state_q;
   logic [3:0] idx_q;
   logic [7:0] csum_q;
   logic [3:0] rx_err_q;
   logic       accept, active, line_flt, expire;
   assign accept   = rx_sent && !rx_ack && state_q != HOLD;
   assign active   = state_q inside {CMD, LEN, PAYLOAD, CSUM};
   assign line_flt = active && rx_err_q == 4'd0 && rx_error != 4'd0;
   uart_frame_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .run_i    (active),
      .clr_i    (accept),
      .expire_o (expire)
   );
   // frame FSM: line fault beats timeout beats length/checksum faults; frame outputs survive faults
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q       <= HUNT;
         rx_ack        <= 1'b0;
         frame_valid   <= 1'b0;
         frame_cmd     <= '0;
         frame_len     <= '0;
         frame_payload <= '0;
         frame_err     <= 1'b0;
         err_code      <= ERR_LINE;
         idx_q         <= '0;
         csum_q        <= '0;
         rx_err_q      <= '0;
      end else begin
         rx_ack    <= accept;
         rx_err_q  <= rx_error;
         frame_err <= 1'b0;
         if (line_flt) begin
            frame_err <= 1'b1;
            err_code  <= ERR_LINE;
            state_q   <= HUNT;
         end else if (expire) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state_q   <= HUNT;
         end else case (state_q)
            HUNT: if (accept && rx_data == SYNC) state_q <= CMD;
            CMD: if (accept) begin
               frame_cmd     <= rx_data;
               frame_payload <= '0;
               csum_q        <= rx_data;
               state_q       <= LEN;
            end
            LEN: if (accept) begin
               if (rx_data > LEN_MAX) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_LEN;
                  state_q   <= HUNT;
               end else begin
                  frame_len   <= rx_data[3:0];
                  csum_q      <= csum_q ^ rx_data;
                  idx_q       <= '0;
                  state_q     <= rx_data == 8'd0 ? DATA_DONE : PAYLOAD;
                  frame_valid <= rx_data == 8'd0 && DATA_DONE == HOLD;
               end
            end
            PAYLOAD: if (accept) begin
               for (int i = 0; i < MAX_LEN; i++)
                  if (idx_q == 4'(i)) frame_payload[8*i +: 8] <= rx_data;
               csum_q <= csum_q ^ rx_data;
               idx_q  <= idx_q + 4'd1;
               if (idx_q == frame_len - 4'd1) begin
                  state_q     <= DATA_DONE;
                  frame_valid <= DATA_DONE == HOLD;
               end
            end
            CSUM: if (accept) begin
               if (rx_data == csum_q) begin
                  state_q     <= HOLD;
                  frame_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_CSUM;
                  state_q   <= HUNT;
               end
            end
            HOLD: if (frame_ready) begin
               state_q     <= HUNT;
               frame_valid <= 1'b0;
            end
            default: state_q <= HUNT;
         endcase
      end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: random frame traffic scored against a byte-count frame model
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;
   localparam int MAX_LEN = 8;
   localparam int TIMEOUT = 16;
`ifdef UART_FRAME_CSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   logic clk = 1'b0, reset = 1'b1, rx_sent = 1'b0, frame_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [3:0] rx_error = 4'h0;
   logic rx_ack, frame_valid, frame_err;
   logic [7:0] frame_cmd;
   logic [3:0] frame_len;
   logic [8*MAX_LEN-1:0] frame_payload;
   logic [1:0] err_code;
   typedef struct {bit is_err; logic [1:0] code; logic [7:0] cmd; logic [3:0] len; logic [63:0] pl;} ev_t;
   ev_t sb[$];
   logic [7:0] fb[$];
   bit coll = 0;
   int tests = 0, fails = 0, cyc = 0, last_ack = 0;

   always #5 clk = ~clk;

   uart_rx_frame_ctrl #(.SYNC(8'hAA), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_sent(rx_sent), .rx_error(rx_error),
      .rx_ack(rx_ack), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .frame_cmd(frame_cmd), .frame_len(frame_len), .frame_payload(frame_payload),
      .frame_err(frame_err), .err_code(err_code));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_err(input logic [1:0] c);
      ev_t e;
      e.is_err = 1'b1; e.code = c; e.cmd = 8'h00; e.len = 4'h0; e.pl = 64'h0;
      sb.push_back(e);
      coll = 0;
   endtask

   // reference: a frame is SYNC then cmd, len, len payload bytes and (optionally) the XOR checksum
   task automatic model_byte(input logic [7:0] b);
      ev_t e;
      logic [7:0] x;
      if (!coll) begin
         coll = (b == 8'hAA);
         fb.delete();
         return;
      end
      fb.push_back(b);
      if (fb.size() == 2 && int'(fb[1]) > MAX_LEN) push_err(2'd2);
      else if (fb.size() >= 2 && fb.size() == 2 + int'(fb[1]) + CS) begin
         x = 8'h00;
         for (int i = 0; i < fb.size() - 1; i++) x ^= fb[i];
         if (CS == 1 && x != fb[fb.size()-1]) push_err(2'd1);
         else begin
            e.is_err = 1'b0; e.code = 2'd0; e.cmd = fb[0]; e.len = fb[1][3:0]; e.pl = 64'h0;
            for (int i = 0; i < int'(fb[1]); i++) e.pl[8*i +: 8] = fb[2+i];
            sb.push_back(e);
            coll = 0;
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      model_byte(b);
      @(negedge clk);
      rx_data = b;
      rx_sent = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rx_ack && n < 200);
      if (!rx_ack) begin
         tests++; fails++;
         $display("FAIL ack wait: byte %h not acknowledged in 200 cycles", b);
      end
      rx_sent = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   function automatic logic [7:0] noise();
      logic [7:0] b;
      b = 8'($urandom);
      return b == 8'hAA ? 8'h55 : b;
   endfunction

   task automatic inject_timeout();
      if (coll) push_err(2'd3);
      repeat (TIMEOUT + 4) @(negedge clk);
   endtask

   task automatic inject_line();
      if (coll) push_err(2'd0);
      @(negedge clk);
      rx_error = 4'($urandom_range(1, 15));
      repeat (2) @(negedge clk);
      rx_error = 4'h0;
      @(negedge clk);
   endtask

   task automatic inject_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check("reset mid-frame outputs", {rx_ack, frame_valid, frame_cmd, frame_len, frame_payload, frame_err, err_code}, 0);
      @(negedge clk);
      reset = 1'b0;
      coll = 0;
      fb.delete();
   endtask

   task automatic rand_frame();
      int kind, len, cut;
      logic [7:0] q[$];
      logic [7:0] x;
      kind = $urandom_range(0, 5);
      repeat ($urandom_range(0, 2)) send_byte(noise());
      len = (kind == 1) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, MAX_LEN);
      q.push_back(8'($urandom));
      q.push_back(len[7:0]);
      if (kind != 1) for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      x = 8'h00;
      foreach (q[i]) x ^= q[i];
      if (CS == 1 && kind != 1) q.push_back(kind == 2 ? ~x : x);
      cut = (kind >= 3) ? $urandom_range(0, q.size() - 1) : q.size();
      send_byte(8'hAA);
      for (int i = 0; i < cut; i++) send_byte(q[i]);
      case (kind)
         1: repeat (2) send_byte(noise());
         3: inject_timeout();
         4: inject_line();
         5: inject_reset();
         default: ;
      endcase
   endtask

   // downstream randomly accepts held frames
   initial forever begin
      @(negedge clk);
      frame_ready = ($urandom_range(0, 2) == 0);
   end

   // monitor: pops the scoreboard whenever a frame or a fault is presented
   initial begin
      logic pv, pa, pend;
      logic [7:0] hc;
      logic [3:0] hl;
      logic [63:0] hp;
      ev_t e;
      pv = 0; pa = 0; pend = 0; hc = 0; hl = 0; hp = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (reset) begin
            pv = 0; pa = 0; pend = 0;
         end else begin
            if (pend) check("ack after release", rx_ack, 1);
            if (pv && rx_sent) check("no ack while held", rx_ack, 0);
            pend = pv && frame_ready && rx_sent;
            if (rx_ack) begin
               check("ack single cycle", pa, 0);
               last_ack = cyc;
            end
            if (frame_valid && pv) check("held frame stable", {frame_cmd, frame_len, frame_payload}, {hc, hl, hp});
            if (frame_valid && !pv) begin
               if (sb.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected frame: cmd %h len %h", frame_cmd, frame_len);
               end else begin
                  e = sb.pop_front();
                  check("event is frame", e.is_err, 0);
                  check("frame cmd", frame_cmd, e.cmd);
                  check("frame len", frame_len, e.len);
                  check("frame payload", frame_payload, e.pl);
               end
               hc = frame_cmd; hl = frame_len; hp = frame_payload;
            end
            if (frame_err) begin
               if (sb.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected fault: err_code %0d", err_code);
               end else begin
                  e = sb.pop_front();
                  check("event is fault", e.is_err, 1);
                  check("err_code", err_code, e.code);
                  if (e.is_err && e.code == 2'd3) check("timeout latency", cyc - last_ack, TIMEOUT);
               end
            end
            pv = frame_valid;
            pa = rx_ack;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      check("reset outputs", {rx_ack, frame_valid, frame_cmd, frame_len, frame_payload, frame_err, err_code}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02);
`ifdef UART_FRAME_CSUM_EN
      send_byte(8'h11);
      send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h12);
      send_byte(8'h55); send_byte(8'hAA); send_byte(8'h20); send_byte(8'h00); send_byte(8'h20);
`else
      send_byte(8'h55); send_byte(8'hAA); send_byte(8'h20); send_byte(8'h00);
`endif
      send_byte(8'hAA); send_byte(8'h10); send_byte(8'h09); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'hAA); send_byte(8'h10);
      inject_timeout();
      send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h01);
      inject_reset();
      send_byte(8'hAA); send_byte(8'h30); send_byte(8'h01); send_byte(8'h7E);
`ifdef UART_FRAME_CSUM_EN
      send_byte(8'h4F);
`endif
      send_byte(8'hAA); send_byte(8'h40); send_byte(8'h03); send_byte(8'h11);
      inject_line();
      repeat (60) rand_frame();
      repeat (60) @(negedge clk);
      check("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
